coincidence_trigger: RTL and testbench



---
 rtl/coincidence_trigger.sv | 202 ++++++++++++++++++++
 tb/tb_coincidence_trigger.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coincidence_trigger.sv
// -----------------------------------------------------------------------------
// coincidence_trigger
//
// Input conditioning in front of the BCD counter bank. Each raw channel
// (btn_a, btn_b) is synchronised into the clk domain, debounced, and
// edge-detected. Every accepted rising edge produces a one-cycle count pulse
// on its own channel. A coincidence pulse is produced when the A and B edges
// land within WINDOW_CYCLES clocks of each other.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset; clears every register
//   btn_a    in   raw channel A, asynchronous to clk, may bounce
//   btn_b    in   raw channel B, asynchronous to clk, may bounce
//   pulse_a  out  one-cycle pulse per accepted A rising edge
//   pulse_b  out  one-cycle pulse per accepted B rising edge
//   pulse_c  out  one-cycle pulse per A/B coincidence, aligned with the
//                 pulse of the second edge of the pair
//   armed    out  high while a coincidence window is open
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level (>=1)
//   WINDOW_CYCLES    largest A-to-B edge separation that still coincides (>=1)
//   CNT_W            width of the debounce and window counters
// -----------------------------------------------------------------------------
module coincidence_trigger #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WINDOW_CYCLES   = 8,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_a,
   input  logic btn_b,
   output logic pulse_a,
   output logic pulse_b,
   output logic pulse_c,
   output logic armed
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Counter increment that holds at full scale instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_B = 2'd1,
      WAIT_A = 2'd2
   } state_t;

   // Channel vectors: bit 0 is A, bit 1 is B.
   logic [1:0]       raw;
   logic [1:0]       meta_p0;
   logic [1:0]       sync_p1;
   logic [1:0]       lvl_p2;
   logic [1:0]       lvl_q_p3;
   logic [1:0]       rise;
   logic [1:0]       pulse_p3;
   logic [CNT_W-1:0] db [2];

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] win;
   logic [CNT_W-1:0] win_nxt;
   logic             coinc_nxt;
   logic             coinc_p3;
   logic             armed_p3;

   assign raw = {btn_b, btn_a};

   // ---- stage p0/p1: two-flop synchroniser ----------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         meta_p0 <= raw;
         sync_p1 <= meta_p0;
      end
   end

   // ---- stage p2: debounce ---------------------------------------------------
   // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples
   // that differ from the current one; any agreeing sample restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_p2 <= '0;
         for (int ch = 0; ch < 2; ch++) begin
            db[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (sync_p1[ch] == lvl_p2[ch]) begin
               db[ch] <= '0;
            end else if (db[ch] == DB_LAST) begin
               lvl_p2[ch] <= sync_p1[ch];
               db[ch]     <= '0;
            end else begin
               db[ch] <= sat_inc(db[ch]);
            end
         end
      end
   end

   // ---- stage p3: edge detect, pulse register and coincidence FSM ----------
   assign rise = lvl_p2 & ~lvl_q_p3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_q_p3 <= '0;
         pulse_p3 <= '0;
      end else begin
         lvl_q_p3 <= lvl_p2;
         pulse_p3 <= rise;
      end
   end

   // The second edge is checked before a repeat of the first, so a cycle with
   // both edges while waiting closes the pair rather than opening a new window.
   always_comb begin
      state_nxt = state;
      win_nxt   = win;
      coinc_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (rise[0] && rise[1]) begin
               coinc_nxt = 1'b1;
            end else if (rise[0]) begin
               state_nxt = WAIT_B;
               win_nxt   = CNT_ONE;
            end else if (rise[1]) begin
               state_nxt = WAIT_A;
               win_nxt   = CNT_ONE;
            end
         end
         WAIT_B: begin
            if (rise[1]) begin
               coinc_nxt = 1'b1;
               state_nxt = IDLE;
               win_nxt   = '0;
            end else if (rise[0]) begin
               win_nxt = CNT_ONE;
            end else if (win == WIN_LAST) begin
               state_nxt = IDLE;
               win_nxt   = '0;
            end else begin
               win_nxt = sat_inc(win);
            end
         end
         WAIT_A: begin
            if (rise[0]) begin
               coinc_nxt = 1'b1;
               state_nxt = IDLE;
               win_nxt   = '0;
            end else if (rise[1]) begin
               win_nxt = CNT_ONE;
            end else if (win == WIN_LAST) begin
               state_nxt = IDLE;
               win_nxt   = '0;
            end else begin
               win_nxt = sat_inc(win);
            end
         end
         default: begin
            state_nxt = IDLE;
            win_nxt   = '0;
         end
      endcase
   end

   // armed is registered from the next state so it tracks (state != IDLE)
   // exactly, with no extra cycle of lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         win      <= '0;
         coinc_p3 <= 1'b0;
         armed_p3 <= 1'b0;
      end else begin
         state    <= state_nxt;
         win      <= win_nxt;
         coinc_p3 <= coinc_nxt;
         armed_p3 <= (state_nxt != IDLE);
      end
   end

   assign pulse_a = pulse_p3[0];
   assign pulse_b = pulse_p3[1];
   assign pulse_c = coinc_p3;
   assign armed   = armed_p3;

endmodule

// File: tb/tb_coincidence_trigger.sv
// -----------------------------------------------------------------------------
// Testbench for coincidence_trigger. A reference model turns the sampled button
// levels into the expected {pulse_a, pulse_b, pulse_c, armed} of every cycle
// and queues it; a separate monitor pops and compares against the DUT.
// Scenario tasks additionally compare pulse totals against stimulus counts.
// -----------------------------------------------------------------------------
module tb_coincidence_trigger;

   localparam int DEB = 4;
   localparam int WIN = 8;

   logic clk = 1'b0;
   logic rst;
   logic btn_a;
   logic btn_b;
   logic pulse_a;
   logic pulse_b;
   logic pulse_c;
   logic armed;

   coincidence_trigger #(
      .DEBOUNCE_CYCLES (DEB),
      .WINDOW_CYCLES   (WIN),
      .CNT_W           (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_a   (btn_a),
      .btn_b   (btn_b),
      .pulse_a (pulse_a),
      .pulse_b (pulse_b),
      .pulse_c (pulse_c),
      .armed   (armed)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_a = 0;
   int n_b = 0;
   int n_c = 0;
   logic [3:0] exp_q[$];

   // ---------------------------------------------------------------------------
   // Reference model, one step per rising clock edge.
   //   h1/h2   : raw level one and two edges ago (synchroniser delay)
   //   shreg   : sliding window of recent synchronised samples; a new level is
   //             accepted once the last DEB samples all disagree with it
   //   pending : 0 none, 1 A edge waiting for B, 2 B edge waiting for A
   // ---------------------------------------------------------------------------
   bit        h1[2];
   bit        h2[2];
   bit        mlvl[2];
   bit        mrise[2];
   bit [31:0] shreg[2];
   int        fill[2];
   int        pending;
   int        pend_t;
   int        cyc;

   always @(posedge clk) begin : model
      bit ra, rb, coinc, arm, s, old, rawv;
      bit [31:0] mask;
      mask = (32'd1 << DEB) - 32'd1;
      if (rst) begin
         for (int ch = 0; ch < 2; ch++) begin
            h1[ch] = 0; h2[ch] = 0; mlvl[ch] = 0; mrise[ch] = 0;
            shreg[ch] = 0; fill[ch] = 0;
         end
         pending = 0;
         pend_t  = 0;
         exp_q.push_back(4'b0000);
      end else begin
         cyc++;
         ra = mrise[0];
         rb = mrise[1];
         coinc = 0;
         if (pending != 0 && (cyc - pend_t) > WIN) pending = 0;
         if (ra && rb) begin
            coinc = 1;
            pending = 0;
         end else if (ra) begin
            if (pending == 2) begin coinc = 1; pending = 0; end
            else begin pending = 1; pend_t = cyc; end
         end else if (rb) begin
            if (pending == 1) begin coinc = 1; pending = 0; end
            else begin pending = 2; pend_t = cyc; end
         end
         arm = (pending != 0) && ((cyc - pend_t) < WIN);
         exp_q.push_back({ra, rb, coinc, arm});
         for (int ch = 0; ch < 2; ch++) begin
            rawv = (ch == 0) ? btn_a : btn_b;
            s = h2[ch];
            h2[ch] = h1[ch];
            h1[ch] = rawv;
            shreg[ch] = (shreg[ch] << 1) | 32'(s);
            fill[ch]++;
            old = mlvl[ch];
            if (fill[ch] >= DEB && (shreg[ch] & mask) == (old ? 32'd0 : mask))
               mlvl[ch] = ~old;
            mrise[ch] = mlvl[ch] & ~old;
         end
      end
   end

   // Monitor: sample 1 ns after each rising edge and compare.
   initial begin : monitor
      logic [3:0] got;
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         got = {pulse_a, pulse_b, pulse_c, armed};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got %b expected an entry", $time, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t {a,b,c,armed} got %b expected %b", $time, got, e);
            end
         end
         n_a += int'(pulse_a === 1'b1);
         n_b += int'(pulse_b === 1'b1);
         n_c += int'(pulse_c === 1'b1);
      end
   end

   task automatic hold(input bit a, input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         btn_a = a;
         btn_b = b;
      end
   endtask

   task automatic check_cnt(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   int a0, b0, c0;

   task automatic snap();
      a0 = n_a; b0 = n_b; c0 = n_c;
   endtask

   task automatic check_totals(input string tag, input int ea, input int eb, input int ec);
      check_cnt({tag, "_pulse_a"}, n_a - a0, ea);
      check_cnt({tag, "_pulse_b"}, n_b - b0, eb);
      check_cnt({tag, "_pulse_c"}, n_c - c0, ec);
   endtask

   initial begin : stim
      int run_a, run_b, n_ab, n_ao, n_bo;
      bit ra_lvl, rb_lvl;
      rst = 1'b1;
      btn_a = 1'b0;
      btn_b = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      hold(0, 0, 5);

      // 1: simultaneous press
      snap();
      hold(1, 1, 15);
      hold(0, 0, 25);
      check_totals("sim_press", 1, 1, 1);

      // 2: B 5 cycles after A
      snap();
      hold(1, 0, 5);
      hold(1, 1, 10);
      hold(0, 1, 5);
      hold(0, 0, 25);
      check_totals("b_after_5", 1, 1, 1);

      // 3: B 12 cycles after A, outside the window
      snap();
      hold(1, 0, 12);
      hold(1, 1, 3);
      hold(0, 1, 12);
      hold(0, 0, 25);
      check_totals("b_after_12", 1, 1, 0);

      // 4: short glitch, then a bouncy press
      snap();
      hold(1, 0, 2);
      hold(0, 0, 10);
      for (int k = 0; k < 5; k++) hold(k % 2 == 0, 0, 2);
      hold(1, 0, 20);
      hold(0, 0, 25);
      check_totals("bounce", 1, 0, 0);

      // 5: 50 presses, every odd one A+B
      snap();
      n_ab = 0; n_ao = 0; n_bo = 0;
      for (int i = 0; i < 50; i++) begin
         if (i % 2 == 1) begin hold(1, 1, 15); n_ab++; end
         else if ((i / 2) % 2 == 0) begin hold(1, 0, 15); n_ao++; end
         else begin hold(0, 1, 15); n_bo++; end
         hold(0, 0, 20);
      end
      check_totals("fifty", n_ao + n_ab, n_bo + n_ab, 25);

      // 6: reset in the middle of an open window
      snap();
      hold(1, 0, 10);
      hold(0, 0, 1);
      rst = 1'b1;
      hold(0, 0, 3);
      rst = 1'b0;
      hold(0, 0, 3);
      hold(0, 1, 15);
      hold(0, 0, 25);
      check_totals("reset_mid", 1, 1, 0);

      // Random bouncing levels on both channels
      run_a = 0; run_b = 0; ra_lvl = 0; rb_lvl = 0;
      for (int i = 0; i < 1500; i++) begin
         if (run_a == 0) begin ra_lvl = ~ra_lvl; run_a = $urandom_range(1, 14); end
         if (run_b == 0) begin rb_lvl = ~rb_lvl; run_b = $urandom_range(1, 14); end
         run_a--; run_b--;
         hold(ra_lvl, rb_lvl, 1);
      end
      hold(0, 0, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
